// File: rtl/sa_skew_feature_loader_if.sv
// Bundle of the loader's controller handshake, memory read port and array-facing lanes.
// The controller pulses start while busy is low; the loader raises busy from the next cycle, pulses done with the final sa_en, and drops busy one cycle later.
interface sa_skew_feature_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int ROWS   = 3
);
  logic                     start;
  logic [ADDR_W-1:0]        feature_base;
  logic                     busy;
  logic                     done;
  logic [ADDR_W-1:0]        addr;
  logic                     rd_en;
  logic [DATA_W-1:0]        q;
  logic [ROWS*DATA_W-1:0]   features;
  logic                     sa_en;

  modport master (
    output start, feature_base, q,
    input  busy, done, addr, rd_en, features, sa_en
  );

  modport slave (
    input  start, feature_base, q,
    output busy, done, addr, rd_en, features, sa_en
  );
endinterface

// File: rtl/sa_skew_feature_loader.sv
// Streams a ROWS x COLS feature tile from 1-cycle-latency memory into skewed systolic lanes.
// Optional macro FEATURE_LOADER_ABORT_EN adds an i_abort input that cancels a running tile.
module sa_skew_feature_loader #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int ROWS       = 3,
  parameter int COLS       = 3,
  parameter int ROW_STRIDE = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
`ifdef FEATURE_LOADER_ABORT_EN
  input  logic                      i_abort,
`endif
  sa_skew_feature_loader_if.slave   bus,
  output logic [1:0]                o_dbg_state
);
  localparam int S   = COLS + ROWS - 1;
  localparam int T_W = (S > 1) ? $clog2(S) : 1;
  localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state, w_next;
  logic [T_W-1:0]    r_t;
  logic [R_W-1:0]    r_r;
  logic [ADDR_W-1:0] r_base;
  logic              r_p_act, r_p_rd, r_p_last, r_p_final;
  logic [R_W-1:0]    r_p_lane;
  logic [DATA_W-1:0] r_lane [ROWS];
  logic              r_sa_en, r_done;

  logic              w_abort, w_start, w_slot, w_row_last, w_step_last, w_valid;
  logic [31:0]       w_e;
  logic [ADDR_W-1:0] w_row_off, w_addr;
  logic [ROWS*DATA_W-1:0] w_features;

`ifdef FEATURE_LOADER_ABORT_EN
  assign w_abort = i_abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_start     = bus.start && (r_state == ST_IDLE);
  assign w_slot      = (r_state == ST_LOAD);
  assign w_row_last  = (r_r == R_W'(ROWS - 1));
  assign w_step_last = (r_t == T_W'(S - 1));

  // Slot (t,r) carries element e=t-r; anything outside 0..COLS-1 is a zero-fill slot.
  assign w_e       = 32'(r_t) - 32'(r_r);
  assign w_valid   = w_slot && (32'(r_t) >= 32'(r_r)) && (w_e < 32'(COLS));
  assign w_row_off = ADDR_W'(32'(r_r) * 32'(ROW_STRIDE));
  assign w_addr    = r_base + w_row_off + ADDR_W'(w_e);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_LOAD;
      ST_LOAD:  if (w_row_last && w_step_last) w_next = ST_DRAIN;
      ST_DRAIN: if (r_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base <= '0;
      r_t    <= '0;
      r_r    <= '0;
    end else if (w_start) begin
      r_base <= bus.feature_base;
      r_t    <= '0;
      r_r    <= '0;
    end else if (w_slot && !w_abort) begin
      if (w_row_last) begin
        r_r <= '0;
        r_t <= r_t + T_W'(1);
      end else begin
        r_r <= r_r + R_W'(1);
      end
    end
  end

  // Slot info travels one stage alongside the memory read so the lane write lines up with q.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort) begin
      r_p_act   <= 1'b0;
      r_p_rd    <= 1'b0;
      r_p_last  <= 1'b0;
      r_p_final <= 1'b0;
      r_p_lane  <= '0;
    end else begin
      r_p_act   <= w_slot;
      r_p_rd    <= w_valid;
      r_p_last  <= w_slot && w_row_last;
      r_p_final <= w_slot && w_row_last && w_step_last;
      r_p_lane  <= r_r;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort) begin
      r_sa_en <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < ROWS; i++) r_lane[i] <= '0;
    end else begin
      r_sa_en <= r_p_act && r_p_last;
      r_done  <= r_p_act && r_p_final;
      for (int i = 0; i < ROWS; i++) begin
        if (r_p_act && (r_p_lane == R_W'(i))) r_lane[i] <= r_p_rd ? bus.q : '0;
      end
    end
  end

  always_comb begin
    w_features = '0;
    for (int i = 0; i < ROWS; i++) w_features[i*DATA_W +: DATA_W] = r_lane[i];
  end

  assign bus.features = w_features;
  assign bus.rd_en    = w_valid;
  assign bus.addr     = w_valid ? w_addr : r_base;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.sa_en    = r_sa_en;
  assign bus.done     = r_done;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_sa_skew_feature_loader.sv
// Directed bench for sa_skew_feature_loader (ROWS=3, COLS=3, STRIDE=3, mem[i]=i+1).
module tb_sa_skew_feature_loader;
  localparam int DATA_W = 8, ADDR_W = 6, ROWS = 3, COLS = 3, ROW_STRIDE = 3;
  localparam int FW = ROWS * DATA_W;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
`ifdef FEATURE_LOADER_ABORT_EN
  logic       abort;
`endif

  sa_skew_feature_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROWS(ROWS)) bus_if ();

  sa_skew_feature_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROWS(ROWS), .COLS(COLS), .ROW_STRIDE(ROW_STRIDE)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef FEATURE_LOADER_ABORT_EN
    .i_abort    (abort),
`endif
    .bus        (bus_if.slave),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [64];
  always @(posedge clk) if (bus_if.rd_en) bus_if.q <= mem[bus_if.addr];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [FW-1:0]     feat [5];
    logic [ADDR_W-1:0] addr [9];
  } tile_vec_t;
  tile_vec_t tv [2];

  logic              rec_sa   [64];
  logic              rec_done [64];
  logic              rec_busy [64];
  logic              rec_rd   [64];
  logic [ADDR_W-1:0] rec_addr [64];
  logic [FW-1:0]     rec_feat [64];

  function automatic logic [FW-1:0] pack3(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
    return {l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic record(input int c);
    rec_sa[c]   = bus_if.sa_en;
    rec_done[c] = bus_if.done;
    rec_busy[c] = bus_if.busy;
    rec_rd[c]   = bus_if.rd_en;
    rec_addr[c] = bus_if.addr;
    rec_feat[c] = bus_if.features;
  endtask

  // driver: start driven in run cycle 0, outputs of cycle c sampled mid-cycle before edge c
  task automatic do_run(input logic [ADDR_W-1:0] base, input int ncyc, input int s1, input int s2,
                        input int rst_c, input int abort_c);
    for (int i = 0; i < 64; i++) begin
      rec_sa[i] = 1'b0; rec_done[i] = 1'b0; rec_busy[i] = 1'b0; rec_rd[i] = 1'b0;
      rec_addr[i] = '0; rec_feat[i] = '0;
    end
    @(negedge clk);
    record(0);
    bus_if.start        = 1'b1;
    bus_if.feature_base = base;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      record(c);
      bus_if.start        = (c == s1) || (c == s2);
      bus_if.feature_base = (c >= 2 && c <= 16) ? base + ADDR_W'(7) : base;
      rst                 = (c == rst_c);
`ifdef FEATURE_LOADER_ABORT_EN
      abort               = (c == abort_c);
`else
      if (abort_c > 0 && c == abort_c) $display("note: abort not built in");
`endif
    end
  endtask

  // scoreboard for one complete tile recorded by do_run
  task automatic check_run(input int v, input int ncyc);
    logic [ADDR_W-1:0] exp_q [$];
    int n_sa, n_done, n_rd;
    n_sa = 0; n_done = 0; n_rd = 0;
    for (int a = 0; a < 9; a++) exp_q.push_back(tv[v].addr[a]);
    check("busy_before_start", 64'(rec_busy[0]), 64'd0);
    check("busy_after_accept", 64'(rec_busy[1]), 64'd1);
    for (int c = 0; c <= ncyc; c++) begin
      if (rec_sa[c]) n_sa++;
      if (rec_done[c]) n_done++;
      if (rec_rd[c]) begin
        n_rd++;
        if (exp_q.size() > 0) check("rd_addr", 64'(rec_addr[c]), 64'(exp_q.pop_front()));
        else check("rd_extra", 64'(rec_addr[c]), 64'hFFFF);
      end
    end
    check("sa_en_count", 64'(n_sa), 64'd5);
    check("rd_en_count", 64'(n_rd), 64'd9);
    check("done_count", 64'(n_done), 64'd1);
    check("done_c17", 64'(rec_done[17]), 64'd1);
    check("busy_c17", 64'(rec_busy[17]), 64'd1);
    for (int t = 0; t < 5; t++) begin
      check($sformatf("sa_en_step%0d", t), 64'(rec_sa[3*t+5]), 64'd1);
      check($sformatf("lanes_step%0d", t), 64'(rec_feat[3*t+5]), 64'(tv[v].feat[t]));
    end
    if (ncyc >= 18) begin
      check("busy_c18", 64'(rec_busy[18]), 64'd0);
      check("lanes_hold_c18", 64'(rec_feat[18]), 64'(tv[v].feat[4]));
    end
  endtask

  initial begin
    int n;
    tv[0].base = 6'd0;
    tv[0].feat = '{pack3(1, 0, 0), pack3(2, 4, 0), pack3(3, 5, 7), pack3(0, 6, 8), pack3(0, 0, 9)};
    tv[0].addr = '{6'd0, 6'd1, 6'd3, 6'd2, 6'd4, 6'd6, 6'd5, 6'd7, 6'd8};
    tv[1].base = 6'd60;
    tv[1].feat = '{pack3(61, 0, 0), pack3(62, 64, 0), pack3(63, 1, 3), pack3(0, 2, 4), pack3(0, 0, 5)};
    tv[1].addr = '{6'd60, 6'd61, 6'd63, 6'd62, 6'd0, 6'd2, 6'd1, 6'd3, 6'd4};
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 1);

    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.feature_base = '0;
    bus_if.q = '0;
`ifdef FEATURE_LOADER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_sa_en", 64'(bus_if.sa_en), 64'd0);
    check("rst_done", 64'(bus_if.done), 64'd0);
    check("rst_rd_en", 64'(bus_if.rd_en), 64'd0);
    check("rst_addr", 64'(bus_if.addr), 64'd0);
    check("rst_lanes", 64'(bus_if.features), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    // base 0 tile and wrapping base 60 tile
    do_run(tv[0].base, 18, -1, -1, -1, -1);
    check_run(0, 18);
    do_run(tv[1].base, 18, -1, -1, -1, -1);
    check_run(1, 18);

    // start pulses while busy ignored, then back-to-back start in cycle 18
    do_run(tv[0].base, 17, 4, 9, -1, -1);
    check_run(0, 17);
    do_run(tv[0].base, 18, -1, -1, -1, -1);
    check_run(0, 18);

    // reset mid-tile in cycle 9
    do_run(tv[1].base, 9, -1, -1, 9, -1);
    @(negedge clk);
    check("midrst_busy", 64'(bus_if.busy), 64'd0);
    check("midrst_sa_en", 64'(bus_if.sa_en), 64'd0);
    check("midrst_lanes", 64'(bus_if.features), 64'd0);
    check("midrst_addr", 64'(bus_if.addr), 64'd0);
    check("midrst_rd_en", 64'(bus_if.rd_en), 64'd0);
    rst = 1'b0;
    do_run(tv[0].base, 18, -1, -1, -1, -1);
    check_run(0, 18);

`ifdef FEATURE_LOADER_ABORT_EN
    // abort in cycle 9, restart in cycle 12
    do_run(tv[0].base, 11, -1, -1, -1, 9);
    check("abort_busy_c10", 64'(rec_busy[10]), 64'd0);
    check("abort_lanes_c10", 64'(rec_feat[10]), 64'd0);
    n = 0;
    for (int c = 10; c <= 11; c++) if (rec_sa[c] || rec_done[c]) n++;
    check("abort_no_sa_en", 64'(n), 64'd0);
    abort = 1'b0;
    do_run(tv[0].base, 18, -1, -1, -1, -1);
    check_run(0, 18);
`else
    n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
